// File: rtl/gpio_filter_pkg.sv
// Shared limits and sizing helpers for the GPIO input filter.
package gpio_filter_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // Out-of-range stage counts are pulled back into the supported window.
    function automatic int clamp_sync(input int stages);
        if (stages < SYNC_STAGES_MIN) begin
            return SYNC_STAGES_MIN;
        end else if (stages > SYNC_STAGES_MAX) begin
            return SYNC_STAGES_MAX;
        end else begin
            return stages;
        end
    endfunction

endpackage

// File: rtl/gpio_filter_bit.sv
// One pin: synchroniser chain, debounce counter, stable level and edge strobes.
module gpio_filter_bit
    import gpio_filter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_i,
    output logic value_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int SYNC_EFF = clamp_sync(SYNC_STAGES);
    localparam int CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_EFF-1:0] sync_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                stable_r;
    logic                rise_r;
    logic                fall_r;
    logic                sync_s;

    assign sync_s = sync_r[SYNC_EFF-1];

    // Metastability synchroniser, oldest sample in the MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_EFF{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_EFF-2:0], pad_i};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else if ((sync_s != stable_r) && (cnt_r == CNT_LAST)) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= sync_s;
            rise_r   <= sync_s;
            fall_r   <= ~sync_s;
        end else if (sync_s != stable_r) begin
            cnt_r    <= cnt_r + CNT_W'(1'b1);
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            cnt_r    <= {CNT_W{1'b0}};
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end
    end

    assign value_o = stable_r;
    assign rise_o  = rise_r;
    assign fall_o  = fall_r;

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO receive-side conditioner: per-pin filters plus sticky edge capture and irq.
module gpio_input_filter
    import gpio_filter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] clear_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] pending_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] value_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] pending_next_s;
    logic [WIDTH-1:0] pending_r;
    logic             irq_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_filter_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pad_i   (pad_i[i]),
            .value_o (value_s[i]),
            .rise_o  (rise_s[i]),
            .fall_o  (fall_s[i])
        );
    end

    // Set terms are OR-ed after the clear so a same-cycle edge is never lost.
    always_comb begin
        pending_next_s = (pending_r & ~clear_i)
                       | (rise_s & rise_en_i)
                       | (fall_s & fall_en_i);
    end

    // irq follows the next-state pending so both change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {WIDTH{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            irq_r     <= |pending_next_s;
        end
    end

    assign value_o   = value_s;
    assign rise_o    = rise_s;
    assign fall_o    = fall_s;
    assign pending_o = pending_r;
    assign irq_o     = irq_r;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Scoreboard bench: tasks push timed expectations, a monitor pops and compares them.
module tb_gpio_input_filter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pad, rise_en, fall_en, clear;
    logic [7:0] value, rise, fall, pending;
    logic       irq;
    logic [7:0] pad1, rise_en1, fall_en1, clear1;
    logic [7:0] value1, rise1, fall1, pending1;
    logic       irq1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    gpio_input_filter u_dut (
        .clk(clk), .reset_n(reset_n), .pad_i(pad), .rise_en_i(rise_en),
        .fall_en_i(fall_en), .clear_i(clear), .value_o(value), .rise_o(rise),
        .fall_o(fall), .pending_o(pending), .irq_o(irq)
    );

    gpio_input_filter #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_fast (
        .clk(clk), .reset_n(reset_n), .pad_i(pad1), .rise_en_i(rise_en1),
        .fall_en_i(fall_en1), .clear_i(clear1), .value_o(value1), .rise_o(rise1),
        .fall_o(fall1), .pending_o(pending1), .irq_o(irq1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0 value, 1 rise, 2 fall, 3 pending, 4 irq, 5 value1, 6 rise1, 7 fall1
    function automatic void push(input int due, input int sel, input logic [7:0] mask,
                                 input logic [7:0] exp, input string name);
        exp_t e;
        e.due = due; e.sel = sel; e.mask = mask; e.exp = exp; e.name = name;
        sb.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scoreboard_monitor();
        logic [7:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    case (sb[i].sel)
                        0:       act = value;
                        1:       act = rise;
                        2:       act = fall;
                        3:       act = pending;
                        4:       act = {7'd0, irq};
                        5:       act = value1;
                        6:       act = rise1;
                        7:       act = fall1;
                        default: act = 8'hxx;
                    endcase
                    vectors++;
                    if ((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                        miscompares++;
                        $display("FAIL %s at edge %0d: got %h, expected %h", sb[i].name, cyc,
                                 act & sb[i].mask, sb[i].exp & sb[i].mask);
                    end
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_reset();
        int c;
        reset_n = 1'b0; pad = 8'hFF; pad1 = 8'hFF;
        step(3);
        vectors += 4;
        if (value !== 8'h00 || rise !== 8'h00) begin
            miscompares++; $display("FAIL reset_value_rise: got %h/%h, expected 00/00", value, rise);
        end
        if (fall !== 8'h00 || pending !== 8'h00) begin
            miscompares++; $display("FAIL reset_fall_pend: got %h/%h, expected 00/00", fall, pending);
        end
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b, expected 0", irq);
        end
        if (value1 !== 8'h00) begin
            miscompares++; $display("FAIL reset_value1: got %h, expected 00", value1);
        end
        reset_n = 1'b1; c = cyc;
        push(c + 17, 0, 8'hFF, 8'h00, "startup_value_early");
        push(c + 18, 0, 8'hFF, 8'hFF, "startup_value");
        push(c + 17, 1, 8'hFF, 8'h00, "startup_rise_early");
        push(c + 18, 1, 8'hFF, 8'hFF, "startup_rise");
        push(c + 19, 1, 8'hFF, 8'h00, "startup_rise_one_cycle");
        push(c + 18, 2, 8'hFF, 8'h00, "startup_no_fall");
        push(c + 20, 3, 8'hFF, 8'h00, "startup_no_pending");
        push(c + 3,  5, 8'hFF, 8'h00, "fast_startup_early");
        push(c + 4,  5, 8'hFF, 8'hFF, "fast_startup_value");
        step(22);
        pad = 8'h00; pad1 = 8'h00; c = cyc;
        push(c + 17, 0, 8'hFF, 8'hFF, "drop_value_early");
        push(c + 18, 0, 8'hFF, 8'h00, "drop_value");
        push(c + 18, 2, 8'hFF, 8'hFF, "drop_fall");
        push(c + 19, 2, 8'hFF, 8'h00, "drop_fall_one_cycle");
        push(c + 18, 1, 8'hFF, 8'h00, "drop_no_rise");
        push(c + 4,  5, 8'hFF, 8'h00, "fast_drop_value");
        push(c + 4,  7, 8'hFF, 8'hFF, "fast_drop_fall");
        step(22);
    endtask

    task automatic test_glitch();
        int c;
        pad[0] = 1'b1; c = cyc;
        step(15);
        pad[0] = 1'b0;
        push(c + 17, 0, 8'h01, 8'h00, "glitch15_value_a");
        push(c + 18, 0, 8'h01, 8'h00, "glitch15_value_b");
        push(c + 20, 0, 8'h01, 8'h00, "glitch15_value_c");
        push(c + 18, 1, 8'h01, 8'h00, "glitch15_no_rise");
        step(6);
        pad[0] = 1'b1; c = cyc;
        push(c + 17, 0, 8'h01, 8'h00, "hold16_value_early");
        push(c + 18, 0, 8'h01, 8'h01, "hold16_value");
        push(c + 18, 1, 8'h01, 8'h01, "hold16_rise");
        push(c + 19, 1, 8'h01, 8'h00, "hold16_rise_one_cycle");
        step(22);
        pad[0] = 1'b0; c = cyc;
        push(c + 18, 2, 8'h01, 8'h01, "hold16_fall");
        step(22);
    endtask

    task automatic test_edge_irq();
        int c;
        rise_en = 8'h08; fall_en = 8'h40;
        pad = 8'h48; c = cyc;
        push(c + 18, 3, 8'hFF, 8'h00, "irq_pending_early");
        push(c + 18, 4, 8'h01, 8'h00, "irq_early");
        push(c + 19, 3, 8'hFF, 8'h08, "irq_pending_rise3");
        push(c + 19, 4, 8'h01, 8'h01, "irq_after_rise3");
        step(25);
        pad = 8'h00; c = cyc;
        push(c + 18, 2, 8'hFF, 8'h48, "irq_falls");
        push(c + 18, 3, 8'hFF, 8'h08, "irq_pending_before_fall");
        push(c + 19, 3, 8'hFF, 8'h48, "irq_pending_fall6");
        step(25);
        clear = 8'h40; c = cyc;
        push(c + 1, 3, 8'hFF, 8'h08, "clear6_pending");
        push(c + 1, 4, 8'h01, 8'h01, "clear6_irq_held");
        step(1);
        clear = 8'h00;
        step(3);
    endtask

    task automatic test_clear_collision();
        int c, f;
        pad[3] = 1'b1; c = cyc;
        push(c + 18, 1, 8'h08, 8'h08, "collide_rise3");
        step(18);
        clear = 8'h08;
        push(c + 19, 3, 8'h08, 8'h08, "collide_set_wins");
        push(c + 19, 4, 8'h01, 8'h01, "collide_irq");
        push(c + 21, 4, 8'h01, 8'h01, "collide_irq_held");
        step(1);
        clear = 8'h00;
        step(3);
        clear = 8'h08; f = cyc;
        push(f + 1, 3, 8'hFF, 8'h00, "clear3_pending");
        push(f + 1, 4, 8'h01, 8'h00, "clear3_irq_drop");
        step(1);
        clear = 8'h00; pad[3] = 1'b0; c = cyc;
        push(c + 20, 3, 8'hFF, 8'h00, "fall3_not_enabled");
        step(22);
        rise_en = 8'h00; fall_en = 8'h00;
    endtask

    task automatic test_reset_mid();
        int c, r;
        pad[5] = 1'b1; c = cyc;
        step(12);
        reset_n = 1'b0;
        #1;
        vectors += 2;
        if (value !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h/%h/%h, expected 00/00/00", value, rise, fall);
        end
        if (pending !== 8'h00 || irq !== 1'b0) begin
            miscompares++; $display("FAIL midreset_pending: got %h/%b, expected 00/0", pending, irq);
        end
        step(1);
        reset_n = 1'b1; r = cyc;
        push(r + 5,  0, 8'h20, 8'h00, "midreset_value_old_deadline");
        push(r + 5,  1, 8'h20, 8'h00, "midreset_no_rise");
        push(r + 17, 0, 8'h20, 8'h00, "midreset_value_early");
        push(r + 18, 0, 8'h20, 8'h20, "midreset_value");
        push(r + 18, 1, 8'h20, 8'h20, "midreset_rise");
        step(22);
        pad[5] = 1'b0;
        step(22);
    endtask

    task automatic test_sweep();
        int c, d;
        pad1 = 8'h0F; c = cyc;
        push(c + 3, 5, 8'hFF, 8'h00, "fast_value_early");
        push(c + 4, 5, 8'hFF, 8'h0F, "fast_value");
        push(c + 4, 6, 8'hFF, 8'h0F, "fast_rise");
        push(c + 5, 6, 8'hFF, 8'h00, "fast_rise_one_cycle");
        step(6);
        pad1 = 8'h8F; d = cyc;
        step(1);
        pad1 = 8'h0F;
        push(d + 4, 5, 8'h80, 8'h80, "fast_glitch_value");
        push(d + 4, 6, 8'h80, 8'h80, "fast_glitch_rise");
        push(d + 5, 5, 8'h80, 8'h00, "fast_glitch_return");
        push(d + 5, 7, 8'h80, 8'h80, "fast_glitch_fall");
        step(8);
    endtask

    initial begin
        reset_n = 1'b0;
        pad = 8'h00; rise_en = 8'h00; fall_en = 8'h00; clear = 8'h00;
        pad1 = 8'h00; rise_en1 = 8'h00; fall_en1 = 8'h00; clear1 = 8'h00;
        fork
            scoreboard_monitor();
        join_none
        step(1);
        test_reset();
        test_glitch();
        test_edge_irq();
        test_clear_collision();
        test_reset_mid();
        test_sweep();
        step(2);
        foreach (sb[i]) begin
            miscompares++;
            $display("FAIL %s never checked (due edge %0d, now %0d)", sb[i].name, sb[i].due, cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
